memory_stage: RTL and testbench

- Downstream consumer of the execute-stage outputs (e_valE, e_Cnd, e_dstE) together with the E-register fields.
- Contains the M pipeline register, the memory address/control logic, and a byte-addressed little-endian data memory with 64-bit accesses.
- Produces m_valM and m_stat for the writeback register and the forwarding paths.

---
 rtl/memory_stage_if.sv | 39 +++
 rtl/memory_stage.sv | 124 ++++++++++++
 tb/tb_memory_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_stage_if                                                            |
// | Execute-side inputs and M-register/memory outputs of the memory stage.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface memory_stage_if;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic        e_Cnd;
    logic [63:0] e_valE;
    logic [63:0] E_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  E_dstM;
    logic        M_bubble;
    logic [2:0]  W_stat;

    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic        dmem_error;

    modport master (
        output E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM, M_bubble, W_stat,
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, m_valM, m_stat, dmem_error
    );

    modport slave (
        input  E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM, M_bubble, W_stat,
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, m_valM, m_stat, dmem_error
    );
endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_stage                                                               |
// | M pipeline register plus byte-addressed little-endian 64-bit data memory.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memory_stage #(
    parameter int         MEM_BYTES = 1024,
    parameter logic [2:0] SAOK      = 3'h1,
    parameter logic [2:0] SHLT      = 3'h2,
    parameter logic [2:0] SADR      = 3'h3,
    parameter logic [2:0] SINS      = 3'h4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    memory_stage_if.slave      bus
);
    localparam int          C_AW        = $clog2(MEM_BYTES);
    localparam logic [63:0] C_LAST_ADDR = 64'(MEM_BYTES - 8);

    localparam logic [3:0] C_ICODE_NOP    = 4'h1;
    localparam logic [3:0] C_ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] C_ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] C_ICODE_CALL   = 4'h8;
    localparam logic [3:0] C_ICODE_RET    = 4'h9;
    localparam logic [3:0] C_ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] C_ICODE_POPQ   = 4'hB;
    localparam logic [3:0] C_REG_NONE     = 4'hF;

    logic [2:0]  r_stat;
    logic [3:0]  r_icode;
    logic        r_cnd;
    logic [63:0] r_val_e;
    logic [63:0] r_val_a;
    logic [3:0]  r_dst_e;
    logic [3:0]  r_dst_m;

    logic [7:0]  r_mem [MEM_BYTES];

    logic [63:0]     w_addr;
    logic            w_rd;
    logic            w_wr;
    logic            w_err;
    logic [C_AW-1:0] w_base;
    logic [63:0]     w_rd_data;
    logic            w_w_stat_ok;
    logic            w_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.M_bubble) begin
            r_stat  <= SAOK;
            r_icode <= C_ICODE_NOP;
            r_cnd   <= 1'b0;
            r_val_e <= '0;
            r_val_a <= '0;
            r_dst_e <= C_REG_NONE;
            r_dst_m <= C_REG_NONE;
        end else begin
            r_stat  <= bus.E_stat;
            r_icode <= bus.E_icode;
            r_cnd   <= bus.e_Cnd;
            r_val_e <= bus.e_valE;
            r_val_a <= bus.E_valA;
            r_dst_e <= bus.e_dstE;
            r_dst_m <= bus.E_dstM;
        end
    end

    // popq/ret read through the old stack pointer carried in valA
    always_comb begin
        w_addr = '0;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        case (r_icode)
            C_ICODE_RMMOVQ, C_ICODE_CALL, C_ICODE_PUSHQ: begin
                w_addr = r_val_e;
                w_wr   = 1'b1;
            end
            C_ICODE_MRMOVQ: begin
                w_addr = r_val_e;
                w_rd   = 1'b1;
            end
            C_ICODE_POPQ, C_ICODE_RET: begin
                w_addr = r_val_a;
                w_rd   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_err  = (w_rd || w_wr) && (w_addr > C_LAST_ADDR);
    assign w_base = w_addr[C_AW-1:0];

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < 8; k++) begin
            w_rd_data[8*k +: 8] = r_mem[w_base + C_AW'(k)];
        end
    end

    assign w_w_stat_ok = (bus.W_stat != SADR) && (bus.W_stat != SINS) && (bus.W_stat != SHLT);
    assign w_commit    = w_wr && !w_err && (r_stat == SAOK) && w_w_stat_ok;

    // Memory has no reset; rst_n only blocks a commit on the aborted edge
    always_ff @(posedge clk) begin
        if (rst_n && w_commit) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[w_base + C_AW'(k)] <= r_val_a[8*k +: 8];
            end
        end
    end

    assign bus.M_stat     = r_stat;
    assign bus.M_icode    = r_icode;
    assign bus.M_Cnd      = r_cnd;
    assign bus.M_valE     = r_val_e;
    assign bus.M_valA     = r_val_a;
    assign bus.M_dstE     = r_dst_e;
    assign bus.M_dstM     = r_dst_m;
    assign bus.m_valM     = (w_rd && !w_err) ? w_rd_data : 64'h0;
    assign bus.dmem_error = w_err;
    assign bus.m_stat     = w_err ? SADR : r_stat;
endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memory_stage                                                            |
// | Directed self-checking bench for the memory stage.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_memory_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    memory_stage_if bus ();

    memory_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction to the E side and move it into M
    task automatic step(input logic [3:0] icode, input logic [63:0] val_e, input logic [63:0] val_a);
        bus.E_icode = icode;
        bus.e_valE  = val_e;
        bus.E_valA  = val_a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n        = 1'b0;
        bus.E_stat   = 3'h1;
        bus.E_icode  = 4'h1;
        bus.e_Cnd    = 1'b0;
        bus.e_valE   = '0;
        bus.E_valA   = '0;
        bus.e_dstE   = 4'hF;
        bus.E_dstM   = 4'hF;
        bus.M_bubble = 1'b0;
        bus.W_stat   = 3'h1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_icode", 64'(bus.M_icode), 64'h1);
        chk("rst_dstE", 64'(bus.M_dstE), 64'hF);
        chk("rst_dstM", 64'(bus.M_dstM), 64'hF);
        chk("rst_stat", 64'(bus.M_stat), 64'h1);
        chk("rst_valM", bus.m_valM, 64'h0);
        chk("rst_err", 64'(bus.dmem_error), 64'h0);
        chk("rst_mstat", 64'(bus.m_stat), 64'h1);
        rst_n = 1'b1;

        step(4'h4, 64'h40, 64'h1122334455667788);
        chk("rm_icode", 64'(bus.M_icode), 64'h4);
        chk("rm_valE", bus.M_valE, 64'h40);
        chk("rm_valA", bus.M_valA, 64'h1122334455667788);
        chk("rm_noread", bus.m_valM, 64'h0);
        step(4'h5, 64'h40, 64'h0);
        chk("mr_read", bus.m_valM, 64'h1122334455667788);
        step(4'h5, 64'h39, 64'h0);
        chk("mr_byte40", 64'(bus.m_valM[63:56]), 64'h88);

        step(4'hA, 64'h3F8, 64'h0102030405060708);
        chk("push_ok_err", 64'(bus.dmem_error), 64'h0);
        step(4'hA, 64'h3F9, 64'hFFEEDDCCBBAA9988);
        chk("push_bad_err", 64'(bus.dmem_error), 64'h1);
        chk("push_bad_mstat", 64'(bus.m_stat), 64'h3);
        step(4'h5, 64'h3F8, 64'h0);
        chk("push_readback", bus.m_valM, 64'h0102030405060708);
        chk("push_readback_mstat", 64'(bus.m_stat), 64'h1);
        step(4'h5, 64'h3F9, 64'h0);
        chk("rd_oob_err", 64'(bus.dmem_error), 64'h1);
        chk("rd_oob_valM", bus.m_valM, 64'h0);
        step(4'h5, 64'hFFFFFFFFFFFFFFF8, 64'h0);
        chk("rd_wrap_err", 64'(bus.dmem_error), 64'h1);

        step(4'h4, 64'h100, 64'hDEAD);
        bus.e_dstE = 4'h4;
        bus.E_dstM = 4'h6;
        step(4'hB, 64'h208, 64'h100);
        chk("pop_valM", bus.m_valM, 64'hDEAD);
        chk("pop_dstE", 64'(bus.M_dstE), 64'h4);
        chk("pop_dstM", 64'(bus.M_dstM), 64'h6);
        bus.e_dstE = 4'hF;
        bus.E_dstM = 4'hF;
        step(4'h9, 64'h108, 64'h100);
        chk("ret_valM", bus.m_valM, 64'hDEAD);

        step(4'h4, 64'h100, 64'hBEEF);
        bus.W_stat = 3'h2;
        step(4'h5, 64'h100, 64'h0);
        chk("wstat_hlt_nowrite", bus.m_valM, 64'hDEAD);
        bus.W_stat = 3'h1;

        bus.E_stat = 3'h4;
        step(4'h4, 64'h100, 64'hBAD);
        chk("mstat_ins", 64'(bus.m_stat), 64'h4);
        bus.E_stat = 3'h1;
        step(4'h5, 64'h100, 64'h0);
        chk("mstat_ins_nowrite", bus.m_valM, 64'hDEAD);

        bus.M_bubble = 1'b1;
        step(4'h4, 64'h100, 64'hCAFE);
        chk("bubble_icode", 64'(bus.M_icode), 64'h1);
        chk("bubble_dstE", 64'(bus.M_dstE), 64'hF);
        chk("bubble_valA", bus.M_valA, 64'h0);
        bus.M_bubble = 1'b0;
        step(4'h5, 64'h100, 64'h0);
        chk("bubble_nowrite", bus.m_valM, 64'hDEAD);

        step(4'h4, 64'h100, 64'h5555);
        chk("abort_store_in_m", 64'(bus.M_icode), 64'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_icode", 64'(bus.M_icode), 64'h1);
        chk("abort_valA", bus.M_valA, 64'h0);
        chk("abort_mstat", 64'(bus.m_stat), 64'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'h5, 64'h100, 64'h0);
        chk("abort_nowrite", bus.m_valM, 64'hDEAD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
